// File: rtl/vram_wr_arb_if.sv
// Bundle of the vram_wr_arb request/grant handshakes and video memory write port.
//   r0_*/r1_* : two requesters; req/cmd/data in, one-cycle ack out
//   vwe/vwx/vwy/vwd : text memory write strobe, column, row, cell data
//   cur_x/cur_y : current cursor position
//   busy : arbiter is executing a multi-cycle command
// slave  : arbiter view (requests in, grants/writes out)
// master : requester/memory-side view
interface vram_wr_arb_if;
  logic       r0_req;
  logic [1:0] r0_cmd;
  logic [8:0] r0_data;
  logic       r0_ack;
  logic       r1_req;
  logic [1:0] r1_cmd;
  logic [8:0] r1_data;
  logic       r1_ack;
  logic       vwe;
  logic [6:0] vwx;
  logic [4:0] vwy;
  logic [8:0] vwd;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  modport slave (
    input  r0_req, r0_cmd, r0_data, r1_req, r1_cmd, r1_data,
    output r0_ack, r1_ack, vwe, vwx, vwy, vwd, cur_x, cur_y, busy
  );

  modport master (
    output r0_req, r0_cmd, r0_data, r1_req, r1_cmd, r1_data,
    input  r0_ack, r1_ack, vwe, vwx, vwy, vwd, cur_x, cur_y, busy
  );
endinterface

// File: rtl/vram_wr_arb.sv
// Two-requester round-robin arbiter driving a text-mode video memory write port.
// Commands: 0 put char, 1 newline, 2 clear screen, 3 home.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : vram_wr_arb_if.slave (requests, acks, write port, cursor, busy)
module vram_wr_arb #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 25
) (
  input logic          clk,
  input logic          rst_n,
  vram_wr_arb_if.slave bus
);

  localparam logic [6:0] ColMax = 7'(COLS - 1);
  localparam logic [4:0] RowMax = 5'(ROWS - 1);
  localparam logic [8:0] Blank  = 9'h020;

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;
  typedef enum logic [1:0] {
    CmdPut     = 2'd0,
    CmdNewline = 2'd1,
    CmdClear   = 2'd2,
    CmdHome    = 2'd3
  } cmd_e;

  state_e     state_q, state_d;
  // High when r1 received the most recent grant, so r0 wins the next contest.
  logic       last_r1_q, last_r1_d;
  logic       vwe_q, vwe_d;
  logic [6:0] vwx_q, vwx_d;
  logic [4:0] vwy_q, vwy_d;
  logic [8:0] vwd_q, vwd_d;
  logic [6:0] cur_x_q, cur_x_d;
  logic [4:0] cur_y_q, cur_y_d;

  logic       gnt0, gnt1, any_gnt;
  cmd_e       cmd_sel;
  logic [8:0] data_sel;
  logic [6:0] adv_x;
  logic [4:0] adv_y, nl_y;
  logic       sweep_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_r1_q <= 1'b1;
      vwe_q     <= 1'b0;
      vwx_q     <= '0;
      vwy_q     <= '0;
      vwd_q     <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_r1_q <= last_r1_d;
      vwe_q     <= vwe_d;
      vwx_q     <= vwx_d;
      vwy_q     <= vwy_d;
      vwd_q     <= vwd_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
    end
  end

  // Grant decode and outputs. Acks are gated by rst_n so none can appear while
  // reset is held, even with a request pending.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle && rst_n) begin
      if (bus.r0_req && bus.r1_req) begin
        gnt0 = last_r1_q;
        gnt1 = !last_r1_q;
      end else begin
        gnt0 = bus.r0_req;
        gnt1 = bus.r1_req;
      end
    end
    any_gnt  = gnt0 | gnt1;
    cmd_sel  = gnt1 ? cmd_e'(bus.r1_cmd) : cmd_e'(bus.r0_cmd);
    data_sel = gnt1 ? bus.r1_data : bus.r0_data;
  end

  assign bus.r0_ack = gnt0;
  assign bus.r1_ack = gnt1;
  assign bus.busy   = (state_q != StIdle);
  assign bus.vwe    = vwe_q;
  assign bus.vwx    = vwx_q;
  assign bus.vwy    = vwy_q;
  assign bus.vwd    = vwd_q;
  assign bus.cur_x  = cur_x_q;
  assign bus.cur_y  = cur_y_q;

  // Cursor arithmetic, wrapping at the screen edges (no scrolling).
  always_comb begin
    nl_y = (cur_y_q == RowMax) ? 5'd0 : cur_y_q + 5'd1;
    if (cur_x_q == ColMax) begin
      adv_x = 7'd0;
      adv_y = nl_y;
    end else begin
      adv_x = cur_x_q + 7'd1;
      adv_y = cur_y_q;
    end
    sweep_last = (vwx_q == ColMax) && (vwy_q == RowMax);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_gnt && cmd_sel == CmdPut)   state_d = StWrite;
        if (any_gnt && cmd_sel == CmdClear) state_d = StClear;
      end
      StWrite: state_d = StIdle;
      StClear: if (sweep_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values; the write port holds unless a write is set up or swept.
  always_comb begin
    last_r1_d = last_r1_q;
    vwe_d     = 1'b0;
    vwx_d     = vwx_q;
    vwy_d     = vwy_q;
    vwd_d     = vwd_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    unique case (state_q)
      StIdle: begin
        if (any_gnt) begin
          last_r1_d = gnt1;
          unique case (cmd_sel)
            CmdPut: begin
              vwe_d = 1'b1;
              vwx_d = cur_x_q;
              vwy_d = cur_y_q;
              vwd_d = data_sel;
            end
            CmdNewline: begin
              cur_x_d = 7'd0;
              cur_y_d = nl_y;
            end
            CmdClear: begin
              vwe_d = 1'b1;
              vwx_d = 7'd0;
              vwy_d = 5'd0;
              vwd_d = Blank;
            end
            CmdHome: begin
              cur_x_d = 7'd0;
              cur_y_d = 5'd0;
            end
            default: ;
          endcase
        end
      end
      StWrite: begin
        cur_x_d = adv_x;
        cur_y_d = adv_y;
      end
      StClear: begin
        if (sweep_last) begin
          cur_x_d = 7'd0;
          cur_y_d = 5'd0;
        end else begin
          vwe_d = 1'b1;
          if (vwx_q == ColMax) begin
            vwx_d = 7'd0;
            vwy_d = vwy_q + 5'd1;
          end else begin
            vwx_d = vwx_q + 7'd1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vram_wr_arb.sv
// Directed bench for vram_wr_arb (80x25): reset, put char, round-robin,
// cursor wrap, clear sweep, newline/home, and reset during a clear.
module tb_vram_wr_arb;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  vram_wr_arb_if bus ();

  vram_wr_arb #(.COLS(80), .ROWS(25)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise a request, wait (bounded) for its ack, step past the grant edge, drop req.
  task automatic issue(input bit who, input logic [1:0] cmd, input logic [8:0] d);
    bit got;
    got = 1'b0;
    if (!who) begin
      bus.r0_req = 1'b1; bus.r0_cmd = cmd; bus.r0_data = d;
    end else begin
      bus.r1_req = 1'b1; bus.r1_cmd = cmd; bus.r1_data = d;
    end
    for (int n = 0; n < 3000 && !got; n++) begin
      #1;
      got = who ? bus.r1_ack : bus.r0_ack;
      if (!got) tick();
    end
    chk("issue_ack", {31'd0, got}, 32'd1);
    tick();
    if (!who) bus.r0_req = 1'b0;
    else      bus.r1_req = 1'b0;
  endtask

  initial begin
    int cnt, bad, ack_busy, busy_lo, wr_after;
    logic [6:0] lastx;
    logic [4:0] lasty;
    bit found;
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    bus.r0_req = 1'b1; bus.r0_cmd = 2'd0; bus.r0_data = 9'h041;
    bus.r1_req = 1'b0; bus.r1_cmd = 2'd0; bus.r1_data = 9'h000;

    // Reset state, with a request pending that must not be acked
    #3;
    chk("rst_vwe", bus.vwe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack0", bus.r0_ack, 0);
    chk("rst_ack1", bus.r1_ack, 0);
    chk("rst_vwx", bus.vwx, 0);
    chk("rst_vwy", bus.vwy, 0);
    chk("rst_vwd", bus.vwd, 0);
    chk("rst_curx", bus.cur_x, 0);
    chk("rst_cury", bus.cur_y, 0);
    bus.r0_req = 1'b0;
    #9 rst_n = 1'b1;
    tick();

    // Single put char from r0
    issue(0, 2'd0, 9'h041);
    chk("put_vwe", bus.vwe, 1);
    chk("put_vwx", bus.vwx, 0);
    chk("put_vwy", bus.vwy, 0);
    chk("put_vwd", bus.vwd, 9'h041);
    chk("put_busy", bus.busy, 1);
    tick();
    chk("put_vwe_off", bus.vwe, 0);
    chk("put_curx", bus.cur_x, 1);
    chk("put_cury", bus.cur_y, 0);
    chk("put_idle", bus.busy, 0);

    // Home via r1 so that r0 wins the next contested grant
    issue(1, 2'd3, 9'h000);
    chk("home1_curx", bus.cur_x, 0);
    chk("home1_vwe", bus.vwe, 0);

    // Both requesters holding put char: r0, r1, r0, r1 with 2-cycle spacing
    bus.r0_req = 1'b1; bus.r0_cmd = 2'd0; bus.r0_data = 9'h061;
    bus.r1_req = 1'b1; bus.r1_cmd = 2'd0; bus.r1_data = 9'h062;
    #1;
    chk("rr_g1_ack0", bus.r0_ack, 1);
    chk("rr_g1_ack1", bus.r1_ack, 0);
    tick();
    bus.r0_data = 9'h063;
    #1;
    chk("rr_w1_acks", {bus.r0_ack, bus.r1_ack}, 0);
    chk("rr_w1", {bus.vwe, bus.vwx, bus.vwy, bus.vwd}, {1'b1, 7'd0, 5'd0, 9'h061});
    tick();
    #1;
    chk("rr_g2_ack1", bus.r1_ack, 1);
    chk("rr_g2_ack0", bus.r0_ack, 0);
    tick();
    bus.r1_data = 9'h064;
    #1;
    chk("rr_w2", {bus.vwe, bus.vwx, bus.vwy, bus.vwd}, {1'b1, 7'd1, 5'd0, 9'h062});
    tick();
    #1;
    chk("rr_g3_ack0", bus.r0_ack, 1);
    chk("rr_g3_ack1", bus.r1_ack, 0);
    tick();
    bus.r0_req = 1'b0;
    #1;
    chk("rr_w3", {bus.vwe, bus.vwx, bus.vwy, bus.vwd}, {1'b1, 7'd2, 5'd0, 9'h063});
    tick();
    #1;
    chk("rr_g4_ack1", bus.r1_ack, 1);
    tick();
    bus.r1_req = 1'b0;
    chk("rr_w4", {bus.vwe, bus.vwx, bus.vwy, bus.vwd}, {1'b1, 7'd3, 5'd0, 9'h064});
    tick();
    chk("rr_cur", {bus.cur_x, bus.cur_y}, {7'd4, 5'd0});

    // Newline at (10,24) wraps to (0,0)
    issue(0, 2'd3, 9'h000);
    for (int i = 0; i < 24; i++) issue(0, 2'd1, 9'h000);
    for (int i = 0; i < 10; i++) issue(0, 2'd0, 9'h030);
    tick();
    chk("nl_pre", {bus.cur_x, bus.cur_y}, {7'd10, 5'd24});
    issue(0, 2'd1, 9'h000);
    chk("nl_wrap", {bus.cur_x, bus.cur_y}, {7'd0, 5'd0});
    chk("nl_vwe", bus.vwe, 0);

    // Home from (5,3)
    for (int i = 0; i < 3; i++) issue(0, 2'd1, 9'h000);
    for (int i = 0; i < 5; i++) issue(0, 2'd0, 9'h031);
    tick();
    chk("home_pre", {bus.cur_x, bus.cur_y}, {7'd5, 5'd3});
    issue(0, 2'd3, 9'h000);
    chk("home_cur", {bus.cur_x, bus.cur_y}, {7'd0, 5'd0});
    chk("home_vwe", bus.vwe, 0);

    // Put char at (79,24) wraps the cursor to (0,0)
    for (int i = 0; i < 24; i++) issue(0, 2'd1, 9'h000);
    for (int i = 0; i < 79; i++) issue(0, 2'd0, 9'h032);
    tick();
    chk("corner_pre", {bus.cur_x, bus.cur_y}, {7'd79, 5'd24});
    issue(0, 2'd0, 9'h05A);
    chk("corner_w", {bus.vwe, bus.vwx, bus.vwy, bus.vwd}, {1'b1, 7'd79, 5'd24, 9'h05A});
    tick();
    chk("corner_cur", {bus.vwe, bus.cur_x, bus.cur_y}, {1'b0, 7'd0, 5'd0});

    // r1 clear contested by r0 put char (r0 was granted last)
    issue(0, 2'd0, 9'h011);
    tick();
    bus.r0_req = 1'b1; bus.r0_cmd = 2'd0; bus.r0_data = 9'h077;
    bus.r1_req = 1'b1; bus.r1_cmd = 2'd2; bus.r1_data = 9'h000;
    #1;
    chk("clr_g_ack1", bus.r1_ack, 1);
    chk("clr_g_ack0", bus.r0_ack, 0);
    tick();
    bus.r1_req = 1'b0;
    cnt = 0; bad = 0; ack_busy = 0; busy_lo = 0; lastx = '0; lasty = '0;
    for (int i = 0; i < 2100; i++) begin
      #1;
      if (bus.vwe !== 1'b1) break;
      if (bus.vwx !== 7'(cnt % 80) || bus.vwy !== 5'(cnt / 80) || bus.vwd !== 9'h020) bad++;
      if (bus.r0_ack !== 1'b0) ack_busy++;
      if (bus.busy !== 1'b1) busy_lo++;
      lastx = bus.vwx;
      lasty = bus.vwy;
      cnt++;
      tick();
    end
    chk("clr_count", cnt, 2000);
    chk("clr_cells", bad, 0);
    chk("clr_no_ack", ack_busy, 0);
    chk("clr_busy", busy_lo, 0);
    chk("clr_last", {lastx, lasty}, {7'd79, 5'd24});
    chk("clr_idle", bus.busy, 0);
    chk("clr_cur", {bus.cur_x, bus.cur_y}, {7'd0, 5'd0});
    chk("clr_next_ack0", bus.r0_ack, 1);
    tick();
    bus.r0_req = 1'b0;
    chk("clr_next_w", {bus.vwe, bus.vwx, bus.vwy, bus.vwd}, {1'b1, 7'd0, 5'd0, 9'h077});
    tick();

    // Reset asserted mid-clear at cell (40,2)
    issue(0, 2'd2, 9'h000);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (bus.vwe === 1'b1 && bus.vwx === 7'd40 && bus.vwy === 5'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_found", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_vwe", bus.vwe, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_cur", {bus.cur_x, bus.cur_y}, {7'd0, 5'd0});
    tick();
    tick();
    rst_n = 1'b1;
    wr_after = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.vwe !== 1'b0 || bus.busy !== 1'b0) wr_after++;
    end
    chk("mid_no_writes", wr_after, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/vram_wr_arb.md
VRAM_WR_ARB -- requirements
Module: vram_wr_arb

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns per row.
REQ-002 SHALL have parameter ROWS, default 25, text rows per screen.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports r0_req / r1_req  input  1 each  requester N has a command pending.
REQ-006 SHALL have ports r0_cmd / r1_cmd  input  2 each  command: 0 put char, 1 newline, 2 clear screen, 3 home.
REQ-007 SHALL have ports r0_data / r1_data  input  9 each  character cell value for put char.
REQ-008 SHALL have ports r0_ack / r1_ack  output  1 each  one-cycle grant; command and data are sampled this cycle.
REQ-009 SHALL have port vwe  output  1  video text memory write enable.
REQ-010 SHALL have ports vwx  output  7, vwy  output  5  write cell column and row.
REQ-011 SHALL have port vwd  output  9  write cell data.
REQ-012 SHALL have ports cur_x  output  7, cur_y  output  5  current cursor position.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, WRITE and CLEAR; busy = (state != IDLE).
REQ-015 SHALL evaluate requests only in IDLE and grant at most one requester per cycle.
REQ-016 SHALL arbitrate round-robin: a lone requester is granted; if both request, grant the one not granted last; the pointer updates on every grant.
REQ-017 SHALL assert rN_ack for exactly the grant cycle; a requester holds req/cmd/data stable until ack and may present a new command the cycle after ack.
REQ-018 SHALL on granting put char (cmd 0): next cycle vwe=1, vwx=cur_x, vwy=cur_y, vwd=data; state WRITE.
REQ-019 SHALL in WRITE: next cycle vwe=0; advance the cursor; return to IDLE; put char costs 2 cycles, grant to grant.
REQ-020 SHALL advance the cursor as cur_x+1; at cur_x=COLS-1, cur_x=0 and cur_y+1; at cur_y=ROWS-1 with that wrap, cur_y=0 (no scroll).
REQ-021 SHALL on granting newline (cmd 1): set cur_x=0, cur_y+1 with the same ROWS-1 to 0 wrap; no memory write; remain IDLE.
REQ-022 SHALL on granting home (cmd 3): set cur_x=0, cur_y=0; no write; remain IDLE.
REQ-023 SHALL on granting clear (cmd 2): enter CLEAR and write 9'h020 to every cell, one per cycle: (0,0), (1,0) through (COLS-1,0), (0,1) through (COLS-1,ROWS-1). vwe=1 for exactly COLS*ROWS consecutive cycles.
REQ-024 SHALL after the final clear write: set vwe=0, cur_x=0, cur_y=0 and return to IDLE.
REQ-025 SHALL assert no ack while busy; requests arriving during WRITE or CLEAR wait and are not lost.
REQ-026 SHALL change vwx, vwy and vwd only in cycles that assert vwe or that set up a write, and otherwise hold them.
REQ-027 SHALL compute all cursor and sweep arithmetic modulo COLS/ROWS; values >= COLS or >= ROWS never appear on vwx/vwy or cur_x/cur_y.

Reset
REQ-028 SHALL on rst_n low, immediately and independent of clk: state=IDLE; vwe, vwx, vwy, vwd, cur_x, cur_y, r0_ack, r1_ack = 0; busy=0; round-robin pointer favours r0 for the first contested grant.
REQ-029 SHALL abort any WRITE or CLEAR in progress on reset with no further writes; operation resumes on the first rising clk edge after rst_n goes high.

Verification
REQ-030 SHALL cover: reset, then r0 put char 9'h041 -> r0_ack 1 cycle; next cycle vwe=1, vwx=0, vwy=0, vwd=9'h041; then vwe=0, cur_x=1.
REQ-031 SHALL cover: r0 and r1 put char held continuously -> acks alternate r0, r1, r0 with one grant every 2 cycles, and cells (0,0),(1,0),(2,0) are written with the matching data.
REQ-032 SHALL cover: cursor at (79,24) with put char 9'h05A -> write at (79,24), then cursor at (0,0).
REQ-033 SHALL cover: r1 clear while r0 requests -> exactly 2000 consecutive vwe cycles of 9'h020 ending at (79,24); busy high throughout; no r0_ack until IDLE; cursor (0,0); r0 granted next.
REQ-034 SHALL cover: newline at cursor (10,24) -> cursor (0,0), no vwe; then home from (5,3) -> cursor (0,0), no vwe.
REQ-035 SHALL cover: rst_n asserted mid-CLEAR at cell (40,2) -> vwe=0 and busy=0 immediately, no further writes, cursor (0,0).
